// File: rtl/game_io_mmio_if.sv
// Processor data-port bus shared by the CPU, dmem and the game I/O block.
// No valid/ready: every clock edge is a transfer, wren qualifies a store, and a load of address_dmem is implied every edge.
interface game_io_mmio_if;
  logic [16:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] proc_data_in;

  modport master (
    output address_dmem,
    output data,
    output wren,
    output q_dmem,
    input  proc_data_in
  );

  modport slave (
    input  address_dmem,
    input  data,
    input  wren,
    input  q_dmem,
    output proc_data_in
  );
endinterface

// File: rtl/game_io_mmio.sv
// Memory-mapped game I/O: joystick codes, player/powerup positions, powerup grab timers and respawn.
// All state is updated on the falling edge of clock.
module game_io_mmio #(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_POWERUPS    = 2,
  parameter int COORD_W         = 32,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int TICKS_PER_STAGE = 100000000,
  parameter int NUM_STAGES      = 7,
  parameter int RESPAWN_TICKS   = 0,
  parameter int P_INIT_X        = 240,
  parameter int P_INIT_Y        = 250,
  parameter int P_STEP          = 100,
  parameter int U_INIT_X        = 300,
  parameter int U_INIT_Y        = 300,
  parameter int U_STEP          = 100
) (
  input  logic                                   clock,
  input  logic                                   reset,
  game_io_mmio_if.slave                          bus,
  input  logic [4*NUM_PLAYERS-1:0]               dir_in,
  output logic [NUM_PLAYERS*COORD_W-1:0]         player_x,
  output logic [NUM_PLAYERS*COORD_W-1:0]         player_y,
  output logic [NUM_POWERUPS*COORD_W-1:0]        powerup_x,
  output logic [NUM_POWERUPS*COORD_W-1:0]        powerup_y,
  output logic [NUM_POWERUPS-1:0]                powerup_visible,
  output logic [NUM_PLAYERS*NUM_POWERUPS-1:0]    player_powerup
);
  localparam int N         = NUM_PLAYERS;
  localparam int M         = NUM_POWERUPS;
  localparam int CNT_W     = (TICKS_PER_STAGE > 1) ? $clog2(TICKS_PER_STAGE) : 1;
  localparam int ST_W      = $clog2(NUM_STAGES + 1);
  localparam int RSP_W     = (RESPAWN_TICKS > 0) ? $clog2(RESPAWN_TICKS + 1) : 1;
  localparam int RSP_LAST  = (RESPAWN_TICKS > 0) ? RESPAWN_TICKS - 1 : 0;
  localparam int DMEM_TOP  = 4096;
  localparam int JOY_BASE  = 4100;
  localparam int PLR_BASE  = 4200;
  localparam int PWR_BASE  = 4300;
  localparam int VIS_ADDR  = 4400;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   ext_t;

  localparam ext_t SW_E = ext_t'(SPRITE_W);
  localparam ext_t SH_E = ext_t'(SPRITE_H);

  coord_t [N-1:0]                px_q, px_d, py_q, py_d;
  coord_t [M-1:0]                ux_q, ux_d, uy_q, uy_d;
  logic   [M-1:0]                vis_q, vis_d;
  logic   [N-1:0][M-1:0]         held_q, held_d;
  logic   [N-1:0][M-1:0][ST_W-1:0]  stage_q, stage_d;
  logic   [N-1:0][M-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic   [M-1:0][RSP_W-1:0]     resp_q, resp_d;
  logic   [31:0]                 rdata_q, rdata_d;

  logic   [N-1:0][M-1:0]         grab;
  logic   [M-1:0]                grabbed;
  logic   [16:0]                 addr;

  assign addr = bus.address_dmem;

  // Inclusive interval overlap, one bit wider than a coordinate so sums never wrap.
  function automatic logic overlap(coord_t ax, coord_t ay, coord_t bx, coord_t by);
    ext_t axe, aye, bxe, bye;
    axe = {1'b0, ax};
    aye = {1'b0, ay};
    bxe = {1'b0, bx};
    bye = {1'b0, by};
    return (axe <= bxe + SW_E) && (bxe <= axe + SW_E) &&
           (aye <= bye + SH_E) && (bye <= aye + SH_E);
  endfunction

  function automatic logic [2:0] joy_code(input logic [3:0] d);
    case (d)
      4'b0000: joy_code = 3'd0;
      4'b0001: joy_code = 3'd1;
      4'b0010: joy_code = 3'd2;
      4'b0100: joy_code = 3'd3;
      4'b1000: joy_code = 3'd4;
      default: joy_code = 3'd5;
    endcase
  endfunction

  // Lowest-numbered overlapping player claims each visible powerup.
  always_comb begin : grab_logic
    logic claimed;
    claimed = 1'b0;
    grab    = '0;
    grabbed = '0;
    for (int k = 0; k < M; k++) begin
      claimed = 1'b0;
      for (int p = 0; p < N; p++) begin
        if (!claimed && vis_q[k] && overlap(px_q[p], py_q[p], ux_q[k], uy_q[k])) begin
          grab[p][k] = 1'b1;
          claimed    = 1'b1;
        end
      end
      grabbed[k] = claimed;
    end
  end

  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    ux_d    = ux_q;
    uy_d    = uy_q;
    vis_d   = vis_q;
    held_d  = held_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    rdata_d = '0;

    if (addr < 17'(DMEM_TOP)) rdata_d = bus.q_dmem;
    for (int p = 0; p < N; p++) begin
      if (addr == 17'(JOY_BASE + p))         rdata_d = {29'b0, joy_code(dir_in[4*p +: 4])};
      if (addr == 17'(PLR_BASE + 3*p))       rdata_d = 32'(px_q[p]);
      if (addr == 17'(PLR_BASE + 3*p + 1))   rdata_d = 32'(py_q[p]);
      if (addr == 17'(PLR_BASE + 3*p + 2))   rdata_d = 32'(held_q[p]);
    end
    for (int k = 0; k < M; k++) begin
      if (addr == 17'(PWR_BASE + 2*k))       rdata_d = 32'(ux_q[k]);
      if (addr == 17'(PWR_BASE + 2*k + 1))   rdata_d = 32'(uy_q[k]);
    end
    if (addr == 17'(VIS_ADDR)) rdata_d = 32'(vis_q);

    if (bus.wren) begin
      for (int p = 0; p < N; p++) begin
        if (addr == 17'(PLR_BASE + 3*p))     px_d[p] = coord_t'(bus.data);
        if (addr == 17'(PLR_BASE + 3*p + 1)) py_d[p] = coord_t'(bus.data);
      end
      for (int k = 0; k < M; k++) begin
        if (addr == 17'(PWR_BASE + 2*k))     ux_d[k] = coord_t'(bus.data);
        if (addr == 17'(PWR_BASE + 2*k + 1)) uy_d[k] = coord_t'(bus.data);
      end
    end

    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < M; k++) begin
        if (grab[p][k]) begin
          stage_d[p][k] = ST_W'(1);
          cnt_d[p][k]   = '0;
          held_d[p][k]  = 1'b1;
        end else if (stage_q[p][k] != '0) begin
          if (cnt_q[p][k] == CNT_W'(TICKS_PER_STAGE - 1)) begin
            cnt_d[p][k] = '0;
            if (stage_q[p][k] == ST_W'(NUM_STAGES)) begin
              stage_d[p][k] = '0;
              held_d[p][k]  = 1'b0;
            end else begin
              stage_d[p][k] = stage_q[p][k] + ST_W'(1);
            end
          end else begin
            cnt_d[p][k] = cnt_q[p][k] + CNT_W'(1);
          end
        end
      end
    end

    // A grabbed powerup was visible, so respawn counting never overlaps a grab.
    for (int k = 0; k < M; k++) begin
      if (grabbed[k]) begin
        vis_d[k]  = 1'b0;
        resp_d[k] = '0;
      end else if ((RESPAWN_TICKS != 0) && !vis_q[k]) begin
        resp_d[k] = resp_q[k] + RSP_W'(1);
        if (resp_q[k] == RSP_W'(RSP_LAST)) vis_d[k] = 1'b1;
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      for (int p = 0; p < N; p++) begin
        px_q[p] <= coord_t'(P_INIT_X + p * P_STEP);
        py_q[p] <= coord_t'(P_INIT_Y);
      end
      for (int k = 0; k < M; k++) begin
        ux_q[k] <= coord_t'(U_INIT_X + k * U_STEP);
        uy_q[k] <= coord_t'(U_INIT_Y);
      end
      vis_q   <= '1;
      held_q  <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      ux_q    <= ux_d;
      uy_q    <= uy_d;
      vis_q   <= vis_d;
      held_q  <= held_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.proc_data_in = rdata_q;
  assign player_x         = px_q;
  assign player_y         = py_q;
  assign powerup_x        = ux_q;
  assign powerup_y        = uy_q;
  assign powerup_visible  = vis_q;
  assign player_powerup   = held_q;
endmodule

// File: tb/tb_game_io_mmio.sv
// Bench for game_io_mmio: vector table, directed grab/timer/respawn/reset sequences, then random traffic
// checked every edge against a remaining-edges model of the game state.
module tb_game_io_mmio;
  localparam int N    = 2;
  localparam int M    = 2;
  localparam int CW   = 32;
  localparam int SW   = 32;
  localparam int SH   = 32;
  localparam int TPS  = 4;
  localparam int NST  = 3;
  localparam int RSP  = 10;
  localparam int HOLD = TPS * NST;

  // ---------------- clock / reset / DUT ----------------
  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [4*N-1:0]     dir_in = '0;
  logic [N*CW-1:0]    player_x, player_y;
  logic [M*CW-1:0]    powerup_x, powerup_y;
  logic [M-1:0]       powerup_visible;
  logic [N*M-1:0]     player_powerup;

  game_io_mmio_if bus_if ();

  game_io_mmio #(
    .NUM_PLAYERS(N), .NUM_POWERUPS(M), .COORD_W(CW), .SPRITE_W(SW), .SPRITE_H(SH),
    .TICKS_PER_STAGE(TPS), .NUM_STAGES(NST), .RESPAWN_TICKS(RSP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus_if),
    .dir_in         (dir_in),
    .player_x       (player_x),
    .player_y       (player_y),
    .powerup_x      (powerup_x),
    .powerup_y      (powerup_y),
    .powerup_visible(powerup_visible),
    .player_powerup (player_powerup)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_px[N], m_py[N], m_ux[M], m_uy[M];
  bit          m_vis[M];
  int          m_hold[N][M];   // edges left with the powerup held
  int          m_resp[M];      // edges left until reappearance

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit ovl(input logic [31:0] ax, input logic [31:0] ay,
                             input logic [31:0] bx, input logic [31:0] by);
    longint lax = ax, lay = ay, lbx = bx, lby = by;
    return (lax <= lbx + SW) && (lbx <= lax + SW) && (lay <= lby + SH) && (lby <= lay + SH);
  endfunction

  function automatic logic [31:0] joy(input logic [3:0] d);
    int ones = $countones(d);
    if (ones == 0) return 0;
    if (ones > 1)  return 5;
    for (int i = 0; i < 4; i++) if (d[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] held_mask(input int p);
    logic [31:0] v = 0;
    for (int k = 0; k < M; k++) v[k] = (m_hold[p][k] > 0);
    return v;
  endfunction

  function automatic logic [31:0] vis_mask();
    logic [31:0] v = 0;
    for (int k = 0; k < M; k++) v[k] = m_vis[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_px[p] = 240 + p * 100;
      m_py[p] = 250;
      for (int k = 0; k < M; k++) m_hold[p][k] = 0;
    end
    for (int k = 0; k < M; k++) begin
      m_ux[k] = 300 + k * 100;
      m_uy[k] = 300;
      m_vis[k] = 1;
      m_resp[k] = 0;
    end
  endtask

  task automatic model_step(input logic [16:0] a, input logic [31:0] d, input logic w,
                            input logic [4*N-1:0] dir, input logic [31:0] qd, input logic r);
    int ai = int'(a);
    logic [31:0] rd = 0;
    int win[M];
    if (r) begin
      model_reset();
      exp_q.push_back(0);
      return;
    end
    if (ai < 4096) rd = qd;
    else if (ai >= 4100 && ai < 4100 + N) rd = joy(dir[4*(ai-4100) +: 4]);
    else if (ai >= 4200 && ai < 4200 + 3*N) begin
      case ((ai - 4200) % 3)
        0: rd = m_px[(ai-4200)/3];
        1: rd = m_py[(ai-4200)/3];
        default: rd = held_mask((ai-4200)/3);
      endcase
    end
    else if (ai >= 4300 && ai < 4300 + 2*M) rd = ((ai - 4300) % 2 == 0) ? m_ux[(ai-4300)/2] : m_uy[(ai-4300)/2];
    else if (ai == 4400) rd = vis_mask();
    exp_q.push_back(rd);

    for (int k = 0; k < M; k++) begin
      win[k] = -1;
      if (m_vis[k])
        for (int p = 0; p < N; p++)
          if (win[k] < 0 && ovl(m_px[p], m_py[p], m_ux[k], m_uy[k])) win[k] = p;
    end
    if (w) begin
      if (ai >= 4200 && ai < 4200 + 3*N) begin
        if ((ai - 4200) % 3 == 0) m_px[(ai-4200)/3] = d;
        if ((ai - 4200) % 3 == 1) m_py[(ai-4200)/3] = d;
      end
      if (ai >= 4300 && ai < 4300 + 2*M) begin
        if ((ai - 4300) % 2 == 0) m_ux[(ai-4300)/2] = d;
        else                      m_uy[(ai-4300)/2] = d;
      end
    end
    for (int p = 0; p < N; p++)
      for (int k = 0; k < M; k++)
        if (m_hold[p][k] > 0) m_hold[p][k]--;
    for (int k = 0; k < M; k++)
      if (!m_vis[k] && RSP > 0) begin
        m_resp[k]--;
        if (m_resp[k] == 0) m_vis[k] = 1;
      end
    for (int k = 0; k < M; k++)
      if (win[k] >= 0) begin
        m_hold[win[k]][k] = HOLD;
        m_vis[k] = 0;
        m_resp[k] = RSP;
      end
  endtask

  task automatic compare_all();
    logic [N*CW-1:0] e_px, e_py;
    logic [M*CW-1:0] e_ux, e_uy;
    logic [M-1:0]    e_vis;
    logic [N*M-1:0]  e_hold;
    for (int p = 0; p < N; p++) begin
      e_px[p*CW +: CW] = m_px[p];
      e_py[p*CW +: CW] = m_py[p];
      for (int k = 0; k < M; k++) e_hold[p*M + k] = (m_hold[p][k] > 0);
    end
    for (int k = 0; k < M; k++) begin
      e_ux[k*CW +: CW] = m_ux[k];
      e_uy[k*CW +: CW] = m_uy[k];
      e_vis[k] = m_vis[k];
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: got no expected load value queued");
    end else begin
      check("proc_data_in", 256'(bus_if.proc_data_in), 256'(exp_q.pop_front()));
    end
    check("player_xy",       256'({player_x, player_y}),   256'({e_px, e_py}));
    check("powerup_xy",      256'({powerup_x, powerup_y}), 256'({e_ux, e_uy}));
    check("powerup_visible", 256'(powerup_visible),        256'(e_vis));
    check("player_powerup",  256'(player_powerup),         256'(e_hold));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [16:0] a, input logic [31:0] d, input logic w,
                       input logic [4*N-1:0] dir, input logic r);
    logic [31:0] qd;
    @(posedge clock);
    qd = $urandom;
    bus_if.address_dmem = a;
    bus_if.data         = d;
    bus_if.wren         = w;
    bus_if.q_dmem       = qd;
    dir_in              = dir;
    reset               = r;
    model_step(a, d, w, dir, qd, r);
    @(negedge clock);
    #1;
    compare_all();
  endtask

  task automatic store(input int a, input int d);
    cycle(17'(a), 32'(d), 1'b1, '0, 1'b0);
  endtask

  task automatic load(input int a);
    cycle(17'(a), 32'($urandom), 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(17'd0, 32'd0, 1'b0, '0, 1'b1);
    cycle(17'd0, 32'd0, 1'b0, '0, 1'b1);
  endtask

  function automatic logic [16:0] rand_addr();
    int sel = $urandom_range(0, 9);
    case (sel)
      0:       return 17'($urandom_range(0, 4095));
      1:       return 17'(4100 + $urandom_range(0, N));
      2, 3:    return 17'(4200 + $urandom_range(0, 3*N));
      4, 5:    return 17'(4300 + $urandom_range(0, 2*M));
      6:       return 17'd4400;
      7:       return 17'($urandom_range(4096, 4500));
      default: return 17'($urandom_range(4096, 131071));
    endcase
  endfunction

  function automatic logic [31:0] rand_data();
    int sel = $urandom_range(0, 9);
    if (sel < 8)  return 32'($urandom_range(200, 500));
    if (sel == 8) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [16:0] addr;
    logic [7:0]  dir;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // ---------------- test sequence ----------------
  initial begin : main
    int vis_at, clr_at;
    bus_if.address_dmem = '0;
    bus_if.data         = '0;
    bus_if.wren         = 1'b0;
    bus_if.q_dmem       = '0;

    vecs.push_back('{"rd_p0x",      17'd4200, 8'h00, 32'd240});
    vecs.push_back('{"rd_p0y",      17'd4201, 8'h00, 32'd250});
    vecs.push_back('{"rd_p0mask",   17'd4202, 8'h00, 32'd0});
    vecs.push_back('{"rd_p1x",      17'd4203, 8'h00, 32'd340});
    vecs.push_back('{"rd_p1y",      17'd4204, 8'h00, 32'd250});
    vecs.push_back('{"rd_u0x",      17'd4300, 8'h00, 32'd300});
    vecs.push_back('{"rd_u0y",      17'd4301, 8'h00, 32'd300});
    vecs.push_back('{"rd_u1x",      17'd4302, 8'h00, 32'd400});
    vecs.push_back('{"rd_u1y",      17'd4303, 8'h00, 32'd300});
    vecs.push_back('{"rd_vis",      17'd4400, 8'h00, 32'd3});
    vecs.push_back('{"rd_unmap206", 17'd4206, 8'h00, 32'd0});
    vecs.push_back('{"rd_unmap304", 17'd4304, 8'h00, 32'd0});
    vecs.push_back('{"rd_unmap099", 17'd4099, 8'h00, 32'd0});
    vecs.push_back('{"rd_unmap102", 17'd4102, 8'h0F, 32'd0});
    vecs.push_back('{"joy_up",      17'd4100, 8'h01, 32'd1});
    vecs.push_back('{"joy_right",   17'd4100, 8'h02, 32'd2});
    vecs.push_back('{"joy_down",    17'd4100, 8'h04, 32'd3});
    vecs.push_back('{"joy_left",    17'd4100, 8'h08, 32'd4});
    vecs.push_back('{"joy_none",    17'd4100, 8'h00, 32'd0});
    vecs.push_back('{"joy_two",     17'd4100, 8'h03, 32'd5});
    vecs.push_back('{"joy1_left",   17'd4101, 8'h80, 32'd4});
    vecs.push_back('{"joy1_two",    17'd4101, 8'h61, 32'd5});
    vecs.push_back('{"joy1_none",   17'd4101, 8'h01, 32'd0});

    do_reset();
    check("reset_rd",  256'(bus_if.proc_data_in), 256'(0));
    check("reset_vis", 256'(powerup_visible),     256'(2'b11));
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].addr, 32'd0, 1'b0, vecs[i].dir, 1'b0);
      check(vecs[i].name, 256'(bus_if.proc_data_in), 256'(vecs[i].exp));
    end

    // Grab and 12-edge hold; player walks away before the powerup respawns.
    do_reset();
    store(4200, 300);
    store(4201, 300);
    check("no_grab_yet", 256'(player_powerup), 256'(0));
    load(0);
    check("grab_held", 256'(player_powerup),  256'(4'b0001));
    check("grab_vis",  256'(powerup_visible), 256'(2'b10));
    load(4202);
    check("rd_mask", 256'(bus_if.proc_data_in), 256'(1));
    store(4200, 1000);
    vis_at = 0;
    clr_at = 0;
    for (int i = 3; i <= 20; i++) begin
      load(0);
      if (vis_at == 0 && powerup_visible[0])  vis_at = i;
      if (clr_at == 0 && !player_powerup[0])  clr_at = i;
    end
    check("hold_edges",    256'(clr_at), 256'(12));
    check("respawn_edges", 256'(vis_at), 256'(10));

    // Grab then relocate the powerup; it respawns at the new place, out of reach.
    do_reset();
    store(4200, 300);
    store(4201, 300);
    load(0);
    store(4300, 500);
    store(4301, 500);
    vis_at = 0;
    for (int i = 3; i <= 15; i++) begin
      load(4400);
      if (vis_at == 0 && powerup_visible[0]) vis_at = i;
    end
    check("reloc_respawn", 256'(vis_at), 256'(10));
    check("reloc_pos",  256'({powerup_x[31:0], powerup_y[31:0]}), 256'({32'd500, 32'd500}));
    check("reloc_vis",  256'(powerup_visible), 256'(2'b11));
    check("reloc_held", 256'(player_powerup),  256'(0));

    // Two players meet the powerup on the same edge, then reset two edges later.
    do_reset();
    store(4300, 2000);
    store(4301, 2000);
    store(4200, 300);
    store(4201, 300);
    store(4203, 300);
    store(4204, 300);
    store(4300, 300);
    store(4301, 300);
    load(0);
    check("tie_held", 256'(player_powerup),  256'(4'b0001));
    check("tie_vis",  256'(powerup_visible), 256'(2'b10));
    load(0);
    cycle(17'd4200, 32'd0, 1'b0, '0, 1'b1);
    check("rst_held", 256'(player_powerup),  256'(0));
    check("rst_vis",  256'(powerup_visible), 256'(2'b11));
    check("rst_px",   256'(player_x),  256'({32'd340, 32'd240}));
    check("rst_py",   256'(player_y),  256'({32'd250, 32'd250}));
    check("rst_ux",   256'(powerup_x), 256'({32'd400, 32'd300}));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cycle(rand_addr(), rand_data(), 1'($urandom_range(0, 1)),
            (4*N)'($urandom_range(0, 255)), ($urandom_range(0, 149) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
